// File: rtl/down_counter.sv
// Loadable, cascadable down-counter for the HDMI TX timing chain.
// Counts a loaded value down to zero, pulses TC_out, then reloads (periodic) or stops (one-shot).
module down_counter #(
    parameter int unsigned width  = 8,
    parameter int unsigned RELOAD = 250
) (
    input  logic             clock,
    input  logic             MR_n,
    input  logic             CEP,
    input  logic             PE_n,
    input  logic [width-1:0] Dn,
    input  logic             auto_reload,
    output logic [width-1:0] Qn_out,
    output logic             TC_out,
    output logic             busy
);

    localparam logic [width-1:0] RELOAD_VAL = width'(RELOAD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [width-1:0] count_q, count_d;
    logic [width-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    logic load;
    logic count_en;
    logic terminal;

    assign load     = !PE_n;
    assign count_en = (state_q == RUN) && CEP && !load;
    // A load always wins over a terminal count on the same edge.
    assign terminal = count_en && (count_q == '0);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge MR_n) begin
        if (!MR_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = RUN;
        end else if (terminal && !auto_reload) begin
            state_d = DONE;
        end
    end

    always_comb begin
        busy = (state_q == RUN);
    end

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = Dn;
            reload_d = Dn;
        end else if (terminal) begin
            tc_d = 1'b1;
            if (auto_reload) begin
                count_d = reload_q;
            end
        end else if (count_en) begin
            count_d = count_q - width'(1);
        end
    end

    always_ff @(posedge clock or negedge MR_n) begin
        if (!MR_n) begin
            count_q  <= '0;
            reload_q <= RELOAD_VAL;
            tc_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign Qn_out = count_q;
    assign TC_out = tc_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter with hand-computed expected values.
module tb_down_counter;

    localparam int W = 8;

    logic         clock;
    logic         MR_n;
    logic         CEP;
    logic         PE_n;
    logic [W-1:0] Dn;
    logic         auto_reload;
    logic [W-1:0] Qn_out;
    logic         TC_out;
    logic         busy;

    int checks;
    int errors;

    down_counter #(.width(W), .RELOAD(250)) dut (
        .clock      (clock),
        .MR_n       (MR_n),
        .CEP        (CEP),
        .PE_n       (PE_n),
        .Dn         (Dn),
        .auto_reload(auto_reload),
        .Qn_out     (Qn_out),
        .TC_out     (TC_out),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int q, input int tc, input int b);
        check({tag, " Qn"}, 32'(Qn_out), 32'(q));
        check({tag, " TC"}, 32'(TC_out), 32'(tc));
        check({tag, " busy"}, 32'(busy), 32'(b));
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] val, input logic cep, input logic ar);
        PE_n        = 1'b0;
        Dn          = val;
        CEP         = cep;
        auto_reload = ar;
        tick();
        PE_n = 1'b1;
    endtask

    task automatic do_reset();
        #2 MR_n = 1'b0;
        #3 MR_n = 1'b1;
        #1;
    endtask

    int ar_q[11]  = '{4, 3, 2, 1, 0, 4, 3, 2, 1, 0, 4};
    int ar_tc[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int os_q[7]   = '{3, 2, 1, 0, 0, 0, 0};
    int os_tc[7]  = '{0, 0, 0, 0, 1, 0, 0};
    int os_b[7]   = '{1, 1, 1, 1, 0, 0, 0};
    logic gap_cep[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int   gap_q[4]   = '{4, 4, 3, 3};

    initial begin
        checks      = 0;
        errors      = 0;
        MR_n        = 1'b0;
        CEP         = 1'b0;
        PE_n        = 1'b1;
        Dn          = '0;
        auto_reload = 1'b0;

        // Reset state
        #12;
        check_out("reset", 0, 0, 0);
        MR_n = 1'b1;
        tick();
        CEP = 1'b1;
        tick();
        check_out("idle ignores CEP", 0, 0, 0);

        // Reset mid-count; CEP during load is ignored
        do_load(8'd10, 1'b1, 1'b1);
        check_out("load 10", 10, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_out($sformatf("count10 c%0d", i), 10 - i, 0, 1);
        end
        #2 MR_n = 1'b0;
        #1;
        check_out("async reset mid-count", 0, 0, 0);
        #2 MR_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_out("no count after reset", 0, 0, 0);

        // Auto-reload period
        do_load(8'd4, 1'b1, 1'b1);
        for (int i = 0; i < 11; i++) begin
            check_out($sformatf("autoreload c%0d", i), ar_q[i], ar_tc[i], 1);
            tick();
        end

        // One-shot
        do_load(8'd3, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            check_out($sformatf("oneshot c%0d", i), os_q[i], os_tc[i], os_b[i]);
            tick();
        end

        // Enable gaps and hold
        do_load(8'd5, 1'b0, 1'b1);
        check_out("gap load", 5, 0, 1);
        for (int i = 0; i < 4; i++) begin
            CEP = gap_cep[i];
            tick();
            check_out($sformatf("gap c%0d", i), gap_q[i], 0, 1);
        end

        // Load collides with terminal count
        do_load(8'd0, 1'b0, 1'b1);
        check_out("collision pre", 0, 0, 1);
        do_load(8'd7, 1'b1, 1'b1);
        check_out("collision load wins", 7, 0, 1);
        tick();
        check_out("collision restart", 6, 0, 1);

        // Dn=0 with auto-reload: TC every cycle, reload_reg holds 0 not 250
        do_reset();
        check_out("reset 2", 0, 0, 0);
        do_load(8'd0, 1'b1, 1'b1);
        check_out("zero load", 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out($sformatf("zero reload c%0d", i), 0, 1, 1);
        end
        CEP = 1'b0;
        tick();
        check_out("zero reload CEP off", 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
